// File: rtl/spi_memory_burst.sv
// -----------------------------------------------------------------------------
// spi_memory_burst
//
// SPI slave front end for an internal register-file RAM of 2**ADDR_W words of
// DATA_W bits. Everything runs on clk: the SPI pins are synchronised and their
// edges are detected in the clk domain, so nothing is clocked by sclk.
//
// Frame (MSB first): ADDR_W address bits, one R/W bit (1 = read), then any
// number of DATA_W-bit data words until cs rises. Each following word in a
// burst uses the next address, wrapping at the top of memory.
//
// Optional feature macro: SPI_MEMORY_BURST_AUTOINC_EN
//   defined   : burst words walk through consecutive addresses
//   undefined : the address never advances; reads repeat mem[addr] and
//               writes overwrite mem[addr] (last word wins)
//
// Ports
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   sclk_pin  in   SPI clock, asynchronous to clk
//   cs_pin    in   SPI chip select, active low
//   mosi_pin  in   master out, slave in
//   miso_pin  out  master in, slave out (0 while not driving)
//   miso_oe   out  MISO pad tristate enable, high only while reading
//   leds      out  debug {frame active, rw, state[1:0]}
// -----------------------------------------------------------------------------
module spi_memory_burst #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic [3:0] leds
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic CPOL_L = (CPOL != 0);
    localparam logic CPHA_L = (CPHA != 0);

    // Address used for the next word of a burst.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_MEMORY_BURST_AUTOINC_EN
        return a + ADDR_W'(1);
`else
        return a;
`endif
    endfunction

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_sh;
    logic              rw;
    logic [DATA_W-1:0] shreg;
    logic              miso_q;
    logic              ld_pend;
    logic              wr_pend;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // Stage p0/p1: two-flop synchronisers; stage p2: edge-detect history.
    // The sync flops clear to 0, so after reset cs must be seen high before a
    // falling edge can be detected -- a frame already in progress is skipped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk_pin;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= cs_pin;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= mosi_pin;
            mosi_p1 <= mosi_p0;
        end
    end

    logic sclk_lead, sclk_trail, sample_edge, shift_edge, cs_fall, cs_rise;

    assign sclk_lead   = (sclk_p1 != CPOL_L) && (sclk_p2 == CPOL_L);
    assign sclk_trail  = (sclk_p1 == CPOL_L) && (sclk_p2 != CPOL_L);
    assign sample_edge = CPHA_L ? sclk_trail : sclk_lead;
    assign shift_edge  = CPHA_L ? sclk_lead  : sclk_trail;
    assign cs_fall     = cs_p2 && !cs_p1;
    assign cs_rise     = !cs_p2 && cs_p1;

    // Frame control: acts on the edges detected from stage p1/p2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr    <= '0;
            addr_sh <= '0;
            rw      <= 1'b0;
            shreg   <= '0;
            miso_q  <= 1'b0;
            ld_pend <= 1'b0;
            wr_pend <= 1'b0;
        end else begin
            ld_pend <= 1'b0;
            wr_pend <= 1'b0;

            // Read word fetch lands one clk after the address settles.
            if (ld_pend)
                shreg <= mem[addr];
            // The RAM write happens this clk (separate block); advance after it.
            if (wr_pend)
                addr <= next_addr(addr);

            case (state)
                S_IDLE: begin
                    if (cs_fall) begin
                        state <= S_ADDR;
                        cnt   <= '0;
                    end
                end
                S_ADDR: begin
                    if (sample_edge) begin
                        addr_sh <= ADDR_W'({addr_sh, mosi_p1});
                        if (cnt == ADDR_LAST) begin
                            // addr_sh already holds the full address; this bit is R/W.
                            addr    <= addr_sh;
                            rw      <= mosi_p1;
                            cnt     <= '0;
                            state   <= mosi_p1 ? S_RD : S_WR;
                            ld_pend <= mosi_p1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_RD: begin
                    if (shift_edge) begin
                        miso_q <= shreg[DATA_W-1];
                        shreg  <= shreg << 1;
                        if (cnt == DATA_LAST) begin
                            // Last bit of the word is out; fetch the next one in
                            // time for the following shift edge (no gap).
                            cnt     <= '0;
                            addr    <= next_addr(addr);
                            ld_pend <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (sample_edge) begin
                        shreg <= {shreg[DATA_W-2:0], mosi_p1};
                        if (cnt == DATA_LAST) begin
                            cnt     <= '0;
                            wr_pend <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
            endcase

            // cs rising ends the frame from any state; partial words are
            // dropped, but a write already pending still completes.
            if (cs_rise) begin
                state  <= S_IDLE;
                rw     <= 1'b0;
                miso_q <= 1'b0;
                cnt    <= '0;
            end
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_pend)
            mem[addr] <= shreg;
    end

    assign miso_oe  = (state == S_RD);
    assign miso_pin = miso_q & miso_oe;
    assign leds     = {(state != S_IDLE), rw, state};

endmodule

// File: tb/tb_spi_memory_burst.sv
// -----------------------------------------------------------------------------
// tb_spi_memory_burst
//
// Three instances of spi_memory_burst:
//   dut0  ADDR_W=7, DATA_W=8,  mode 0 (CPOL=0, CPHA=0)
//   dut1  ADDR_W=7, DATA_W=8,  mode 3 (CPOL=1, CPHA=1)
//   dut2  ADDR_W=4, DATA_W=16, mode 0
// An SPI master task set drives frames with sclk = clk/10; a word-level memory
// model per instance supplies expected read data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_memory_burst;

    localparam int HALF = 5;

`ifdef SPI_MEMORY_BURST_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct {
        int          d;
        int          addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] sclk, cs, mosi;
    wire  [2:0] miso, oe;
    wire  [3:0] leds0, leds1, leds2;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mm [3][128];
    bit          mv [3][128];

    always #5 clk = ~clk;

    spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .CPOL(0), .CPHA(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .sclk_pin(sclk[0]), .cs_pin(cs[0]),
        .mosi_pin(mosi[0]), .miso_pin(miso[0]), .miso_oe(oe[0]), .leds(leds0));

    spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .CPOL(1), .CPHA(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .sclk_pin(sclk[1]), .cs_pin(cs[1]),
        .mosi_pin(mosi[1]), .miso_pin(miso[1]), .miso_oe(oe[1]), .leds(leds1));

    spi_memory_burst #(.ADDR_W(4), .DATA_W(16), .CPOL(0), .CPHA(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .sclk_pin(sclk[2]), .cs_pin(cs[2]),
        .mosi_pin(mosi[2]), .miso_pin(miso[2]), .miso_oe(oe[2]), .leds(leds2));

    function automatic int aw(input int d);
        return (d == 2) ? 4 : 7;
    endfunction

    function automatic int dw(input int d);
        return (d == 2) ? 16 : 8;
    endfunction

    function automatic bit cp(input int d);
        return (d == 1);
    endfunction

    function automatic bit ch(input int d);
        return (d == 1);
    endfunction

    function automatic logic [3:0] leds_of(input int d);
        case (d)
            0:       return leds0;
            1:       return leds1;
            default: return leds2;
        endcase
    endfunction

    // Word k of a burst starting at addr lands here.
    function automatic int word_addr(input int d, input int addr, input int k);
        int depth;
        depth = 1 << aw(d);
        return AUTOINC ? ((addr + k) % depth) : (addr % depth);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic build_bits(input int d, input int addr, input bit rw,
                              input logic [15:0] words[$], input int ndata,
                              output bit bits[$]);
        bits.delete();
        for (int i = aw(d) - 1; i >= 0; i--)
            bits.push_back(bit'((addr >> i) & 1));
        bits.push_back(rw);
        for (int j = 0; j < ndata; j++) begin
            logic [15:0] w;
            w = words[j / dw(d)];
            bits.push_back(w[dw(d) - 1 - (j % dw(d))]);
        end
    endtask

    // Clock bits out as the SPI master; capture MISO and MISO_OE at the
    // master's sample edge for every bit.
    task automatic shift_bits(input int d, input bit bits[$], output bit rx[$], output bit oev[$]);
        rx.delete();
        oev.delete();
        foreach (bits[i]) begin
            if (!ch(d)) begin
                mosi[d] = bits[i];
                half_period();
                rx.push_back(miso[d]);
                oev.push_back(oe[d]);
                sclk[d] = ~cp(d);
                half_period();
                sclk[d] = cp(d);
            end else begin
                sclk[d] = ~cp(d);
                mosi[d] = bits[i];
                half_period();
                rx.push_back(miso[d]);
                oev.push_back(oe[d]);
                sclk[d] = cp(d);
                half_period();
            end
        end
        if (!ch(d))
            half_period();
    endtask

    task automatic frame(input int d, input int addr, input bit rw,
                         input logic [15:0] words[$], input int ndata,
                         output logic [15:0] rwords[$], output bit oe_ok);
        bit bits[$];
        bit rx[$];
        bit oev[$];
        cs[d] = 1'b0;
        half_period();
        build_bits(d, addr, rw, words, ndata, bits);
        shift_bits(d, bits, rx, oev);
        cs[d] = 1'b1;
        repeat (8) @(negedge clk);
        oe_ok = 1'b1;
        foreach (oev[i])
            if (oev[i] != ((i > aw(d)) ? rw : 1'b0))
                oe_ok = 1'b0;
        rwords.delete();
        for (int w = 0; w < ndata / dw(d); w++) begin
            logic [15:0] v;
            v = '0;
            for (int b = 0; b < dw(d); b++)
                v = {v[14:0], rx[aw(d) + 1 + w * dw(d) + b]};
            rwords.push_back(v);
        end
    endtask

    task automatic model_write(input int d, input int addr, input logic [15:0] words[$], input int nfull);
        for (int k = 0; k < nfull; k++) begin
            int idx;
            idx = word_addr(d, addr, k);
            mm[d][idx] = words[k] & 16'((1 << dw(d)) - 1);
            mv[d][idx] = 1'b1;
        end
    endtask

    task automatic write_frame(input int d, input int addr, input logic [15:0] words[$], input string name);
        logic [15:0] rq[$];
        bit          ok;
        frame(d, addr, 1'b0, words, words.size() * dw(d), rq, ok);
        check({name, "_wr_oe"}, ok, 1);
        model_write(d, addr, words, words.size());
    endtask

    task automatic write1(input int d, input int addr, input logic [15:0] w, input string name);
        logic [15:0] wq[$];
        wq.push_back(w);
        write_frame(d, addr, wq, name);
    endtask

    task automatic read_frame(input int d, input int addr, input int n, input string name,
                              output logic [15:0] rq[$]);
        logic [15:0] dummy[$];
        bit          ok;
        for (int k = 0; k < n; k++)
            dummy.push_back(16'($urandom));
        frame(d, addr, 1'b1, dummy, n * dw(d), rq, ok);
        check({name, "_rd_oe"}, ok, 1);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = word_addr(d, addr, k);
            if (mv[d][idx])
                check($sformatf("%s_w%0d", name, k), rq[k], mm[d][idx]);
        end
    endtask

    initial begin
        vec_t        tbl [7];
        logic [15:0] rq[$];
        logic [15:0] wq[$];
        bit          bits[$];
        bit          rx[$];
        bit          oev[$];
        bit          ok;

        tbl[0] = '{0, 'h12, 16'h00A5, 16'h00A5};
        tbl[1] = '{1, 'h12, 16'h00A5, 16'h00A5};
        tbl[2] = '{2, 'h3,  16'hBEEF, 16'hBEEF};
        tbl[3] = '{0, 'h00, 16'h00FF, 16'h00FF};
        tbl[4] = '{0, 'h7F, 16'h0000, 16'h0000};
        tbl[5] = '{2, 'hF,  16'h0001, 16'h0001};
        tbl[6] = '{1, 'h55, 16'h0080, 16'h0080};

        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 128; a++)
                mv[d][a] = 1'b0;

        // Reset state
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            cs[d]   = 1'b1;
            sclk[d] = cp(d);
            mosi[d] = 1'b0;
        end
        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_miso%0d", d), miso[d], 0);
            check($sformatf("reset_oe%0d", d), oe[d], 0);
            check($sformatf("reset_leds%0d", d), leds_of(d), 0);
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Table: single write then single read back, all three configurations
        for (int i = 0; i < 7; i++) begin
            write1(tbl[i].d, tbl[i].addr, tbl[i].wdata, $sformatf("tbl%0d", i));
            read_frame(tbl[i].d, tbl[i].addr, 1, $sformatf("tbl%0d", i), rq);
            check($sformatf("tbl%0d_data", i), rq[0], tbl[i].exp);
            check($sformatf("tbl%0d_idle_leds", i), leds_of(tbl[i].d), 0);
            check($sformatf("tbl%0d_idle_oe", i), oe[tbl[i].d], 0);
        end

        // Reset mid-write, then a complete frame without a cs high/low
        write1(0, 'h40, 16'h0011, "rst_pre");
        cs[0] = 1'b0;
        half_period();
        wq.delete();
        wq.push_back(16'h0099);
        build_bits(0, 'h40, 1'b0, wq, 3, bits);
        shift_bits(0, bits, rx, oev);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_leds", leds_of(0), 0);
        reset_n = 1'b1;
        half_period();
        wq.delete();
        wq.push_back(16'h005A);
        build_bits(0, 'h40, 1'b0, wq, 8, bits);
        shift_bits(0, bits, rx, oev);
        check("unjoined_leds", leds_of(0), 0);
        check("unjoined_oe", oe[0], 0);
        cs[0] = 1'b1;
        repeat (8) @(negedge clk);
        read_frame(0, 'h40, 1, "unjoined_ram", rq);
        check("unjoined_ram_explicit", rq[0], 16'h0011);
        write1(0, 'h40, 16'h005A, "fresh");
        read_frame(0, 'h40, 1, "fresh", rq);
        check("fresh_explicit", rq[0], 16'h005A);

        // Abort after 5 data bits of a write
        write1(0, 'h20, 16'h003C, "abort_pre");
        wq.delete();
        wq.push_back(16'h00FF);
        frame(0, 'h20, 1'b0, wq, 5, rq, ok);
        check("abort_leds", leds_of(0), 0);
        check("abort_oe", oe[0], 0);
        read_frame(0, 'h20, 1, "abort_ram", rq);
        check("abort_ram_explicit", rq[0], 16'h003C);

        // Burst write across the top of memory
        write1(0, 'h00, 16'h00EE, "wrap_pre0");
        write1(0, 'h01, 16'h00DD, "wrap_pre1");
        wq.delete();
        wq.push_back(16'h0001);
        wq.push_back(16'h0002);
        wq.push_back(16'h0003);
        write_frame(0, 'h7F, wq, "wrap");
        read_frame(0, 'h7F, 1, "wrap_7f", rq);
        check("wrap_7f_explicit", rq[0], AUTOINC ? 16'h0001 : 16'h0003);
        read_frame(0, 'h00, 1, "wrap_00", rq);
        check("wrap_00_explicit", rq[0], AUTOINC ? 16'h0002 : 16'h00EE);
        read_frame(0, 'h01, 1, "wrap_01", rq);
        check("wrap_01_explicit", rq[0], AUTOINC ? 16'h0003 : 16'h00DD);

        // Burst read of four preloaded words, back to back
        write1(0, 'h10, 16'h0011, "bread_pre0");
        write1(0, 'h11, 16'h0022, "bread_pre1");
        write1(0, 'h12, 16'h0033, "bread_pre2");
        write1(0, 'h13, 16'h0044, "bread_pre3");
        read_frame(0, 'h10, 4, "bread", rq);
        check("bread_w3_explicit", rq[3], AUTOINC ? 16'h0044 : 16'h0011);

        // Randomised frames on every instance against the model
        for (int d = 0; d < 3; d++) begin
            int last_addr;
            last_addr = 0;
            for (int n = 0; n < 12; n++) begin
                int addr;
                int nw;
                addr = ($urandom_range(0, 1) == 1) ? last_addr : int'($urandom_range(0, (1 << aw(d)) - 1));
                nw   = $urandom_range(1, 3);
                if ($urandom_range(0, 1) == 1) begin
                    wq.delete();
                    for (int k = 0; k < nw; k++)
                        wq.push_back(16'($urandom) & 16'((1 << dw(d)) - 1));
                    write_frame(d, addr, wq, $sformatf("rnd_d%0d_n%0d", d, n));
                    last_addr = addr;
                end else begin
                    read_frame(d, addr, nw, $sformatf("rnd_d%0d_n%0d", d, n), rq);
                end
            end
            check($sformatf("rnd_d%0d_idle_leds", d), leds_of(d), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
